// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the register file: widths, register count and the
// encodings used by the write-back / ID-stage handshake signals.
package reg_file_wb_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;
  localparam int RegNum      = 32;
  localparam int RegNumLog2  = 5;
  localparam int CountW      = 16;

  localparam logic [RegBusW-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBusW-1:0] NOPRegAddr   = '0;
  localparam logic                   RstEnable    = 1'b1;
  localparam logic                   WriteEnable  = 1'b1;
  localparam logic                   WriteDisable = 1'b0;
  localparam logic                   ReadEnable   = 1'b1;
  localparam logic                   ReadDisable  = 1'b0;
  localparam logic [CountW-1:0]      CountMax     = '1;

  typedef enum logic [2:0] {
    SelReset,
    SelDisabled,
    SelZeroReg,
    SelBypass,
    SelArray
  } read_sel_e;

  // Saturating increment so the debug counter never wraps back to zero.
  function automatic logic [CountW-1:0] satInc(input logic [CountW-1:0] value);
    return (value == CountMax) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/reg_file_wb_rf_read_port.sv
// One combinational read port: priority mux between reset, disable, the
// hard-wired zero register, same-cycle write bypass and the stored array word.
module rf_read_port
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_data,
  output logic [DATA_W-1:0] rdata
);

  read_sel_e sel;

  always_comb begin
    sel = SelArray;
    if (rst == RstEnable) begin
      sel = SelReset;
    end else if (re == ReadDisable) begin
      sel = SelDisabled;
    end else if (raddr == '0) begin
      sel = SelZeroReg;
    end else if ((we == WriteEnable) && (waddr == raddr)) begin
      sel = SelBypass;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SelBypass: rdata = wdata;
      SelArray:  rdata = array_data;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32 x 32 architectural register file: one synchronous write port from
// write-back, two bypassed combinational read ports for the ID stage.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W   = RegBusW,
  parameter int ADDR_W   = RegAddrBusW,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              commit;

  // Writes to r0 are dropped entirely so r0 stays zero and is never counted.
  assign commit = (we == WriteEnable) && (waddr != NOPRegAddr);

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) begin
      wr_count_d = satInc(wr_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      if (commit) begin
        regs_q[waddr] <= wdata;
      end
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .rst        (rst),
    .re         (re1),
    .raddr      (raddr1),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .array_data (regs_q[raddr1]),
    .rdata      (rdata1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .rst        (rst),
    .re         (re2),
    .raddr      (raddr2),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .array_data (regs_q[raddr2]),
    .rdata      (rdata2)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus random traffic
// compared against an array-based model of the register file.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];
  int          modelCount = 0;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .wr_count (wr_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // What a reader of the ID stage should see given the current cycle's inputs.
  function automatic logic [31:0] expRead(input bit r, input bit w, input logic [4:0] wa,
                                          input logic [31:0] wd, input bit e,
                                          input logic [4:0] a);
    if (r || !e || a == 0) return 32'h0;
    if (w && wa == a) return wd;
    return model[a];
  endfunction

  // Drive one cycle, check both read ports before the edge, then retire the
  // cycle into the model and check the write counter after the edge.
  task automatic applyStimulus(input bit r, input bit w, input logic [4:0] wa,
                               input logic [31:0] wd, input bit e1, input logic [4:0] a1,
                               input bit e2, input logic [4:0] a2, input bit chk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #2;
    if (chk) begin
      checkOutput("rdata1", rdata1, expRead(r, w, wa, wd, e1, a1));
      checkOutput("rdata2", rdata2, expRead(r, w, wa, wd, e2, a2));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      modelCount = 0;
    end else if (w && wa != 0) begin
      model[wa] = wd;
      if (modelCount < 65535) modelCount++;
    end
    #1;
    if (chk) checkOutput("wr_count", {16'h0, wr_count}, modelCount);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset held two cycles with a write pending that must be discarded.
    applyStimulus(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 1, 5, 1);
    applyStimulus(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 1, 5, 1);
    applyStimulus(0, 0, 0, 0, 1, 5, 1, 5, 1);
    checkOutput("reset_r5", rdata1, 32'h0);
    checkOutput("reset_count", {16'h0, wr_count}, 32'h0);

    // Write then read on both ports.
    applyStimulus(0, 1, 3, 32'h1234_5678, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 3, 1, 3, 1);
    checkOutput("wr_r3_p1", rdata1, 32'h1234_5678);
    checkOutput("wr_r3_p2", rdata2, 32'h1234_5678);
    checkOutput("wr_count1", {16'h0, wr_count}, 32'h1);

    // Same-cycle bypass on both ports.
    applyStimulus(0, 1, 7, 32'hA5A5_A5A5, 1, 7, 1, 7, 1);

    // Zero register ignores writes, including during the write cycle.
    applyStimulus(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("r0_count", {16'h0, wr_count}, 32'h2);

    // Read disable on port 2.
    applyStimulus(0, 1, 9, 32'h55, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 40) == 0), $urandom_range(0, 1),
                    5'($urandom_range(0, 31)), $urandom,
                    ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)), 1);
    end

    // Counter saturation, then reset with a pending write to r4.
    for (int n = 0; n < 65540; n++) begin
      applyStimulus(0, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0, 0, 0);
    end
    checkOutput("sat_count", {16'h0, wr_count}, 32'hFFFF);
    applyStimulus(0, 1, 4, 32'hCAFE_0004, 1, 4, 1, 4, 1);
    checkOutput("sat_hold", {16'h0, wr_count}, 32'hFFFF);
    applyStimulus(1, 1, 4, 32'h0BAD_0004, 1, 4, 1, 4, 1);
    applyStimulus(0, 0, 0, 0, 1, 4, 1, 1, 1);
    checkOutput("midrst_r4", rdata1, 32'h0);
    checkOutput("midrst_count", {16'h0, wr_count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
